quiz_display_seq: RTL and testbench
===================================

Name: quiz_display_seq

Overview:
- Downstream display sequencer for the arithmetic quiz core.
- On a start strobe it latches the two operands, the operator code and the computed result, then steps them onto the single 7-segment display one at a time, with a timed blank gap between items.
- It replaces the simulation-only delays of the current display path with a synthesizable, counter-timed state machine.
- The result is converted to two decimal digits internally by repeated subtraction.

Parameters:
- HOLD_CYCLES, default 150000000, clock cycles each digit is shown (3 s at 50 MHz).
- GAP_CYCLES, default 5000000, clock cycles of blank display between digits.
- CNT_W, default 28, width of the dwell counter; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to display a new question.
- num_a  input  4  first operand, valid 0..9.
- num_b  input  4  second operand, valid 0..9.
- op  input  2  operator code: 0 add, 1 sub, 2 mul, 3 reserved.
- result  input  7  answer, valid 0..99.
- num_led  output  7  segments abcdefg, active-high, 1 = lit.
- op_led  output  3  one-hot operator indicator: bit0 add, bit1 sub, bit2 mul.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset values (asserted asynchronously): state IDLE, num_led 0000000, op_led 000, busy 0, done 0, counters 0, latched values 0.
- Start acceptance:
  - start is sampled only in IDLE or DONE; it is ignored while busy.
  - On acceptance, num_a, num_b, op and result are latched in that cycle.
  - State becomes CONV; busy goes high on the same edge.
- op_led decode:
  - Decoded from the latched op; op=3 gives 000.
  - Updated on the accepting edge and held until the next accepted start or reset.
- States and transitions:
  - IDLE: wait for start.
  - CONV: each cycle, if rem >= 10 then rem -= 10 and tens += 1; otherwise go to SHOW_A. Lasts floor(result/10)+1 cycles.
  - CONV with result > 99: skip subtraction, set the error flag, exit after 1 cycle.
  - SHOW_A, GAP1, SHOW_B, GAP2, SHOW_T, GAP3, SHOW_U: each SHOW_* lasts exactly HOLD_CYCLES cycles; each GAP* lasts exactly GAP_CYCLES cycles.
  - From GAP2: if tens == 0 and no error, go directly to SHOW_U, skipping SHOW_T and GAP3.
  - After SHOW_U, go to DONE.
  - DONE: busy 0; done high for only the first cycle in DONE; num_led keeps showing the units digit until the next accepted start or reset.
- Dwell counter:
  - Counts 0..N-1 and reloads 0 on every state change.
  - A single shared counter is used.
- num_led:
  - Registered and updated on the same edge as the state change, so each digit is visible for exactly its dwell.
  - All GAP states, IDLE and CONV show 0000000.
  - Digit encodings: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011.
  - Operand > 9 displays dash 0000001.
  - Error flag set: SHOW_T and SHOW_U both display dash.
- Simultaneous events:
  - Reset dominates start.
  - start in the same cycle the machine enters DONE is ignored; it must arrive while already in DONE.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2):
1. Add with two-digit result:
   - Stimulus: num_a=7, num_b=3, op=0, result=10, start pulse.
   - CONV lasts 2 cycles.
   - num_led shows 1110000 ×4, blank ×2, 1111001 ×4, blank ×2, 0110000 ×4, blank ×2, 1111110 ×4.
   - busy high for 24 cycles, then done pulses one cycle.
   - op_led=001; num_led holds 1111110 afterwards.
2. Mul with single-digit result:
   - Stimulus: num_a=5, num_b=1, op=2, result=5.
   - Tens skipped; busy high 17 cycles.
   - Sequence is 1011011, blank, 0110000, blank, 1011011.
   - op_led=100.
3. Max result:
   - Stimulus: num_a=9, num_b=9, op=2, result=81.
   - CONV lasts 9 cycles.
   - Tens shows 1111111, units shows 0110000.
   - busy high 31 cycles.
4. Start while busy:
   - Stimulus: second start with different inputs during SHOW_B.
   - Ignored; the original sequence completes unchanged.
   - A start issued in DONE is then accepted next cycle.
5. Invalid inputs:
   - Stimulus: num_a=12, result=120, op=3.
   - SHOW_A shows 0000001; SHOW_T and SHOW_U both show 0000001.
   - CONV lasts 1 cycle; op_led=000.
6. Async reset mid-sequence:
   - Stimulus: assert reset between clock edges during SHOW_B.
   - num_led, op_led, busy and done go to 0 immediately without a clock edge.
   - After release, a new start runs a complete correct sequence.

Source files
------------

// File: rtl/quiz_display_seq.sv
// Display sequencer for the arithmetic quiz: latches a question, converts the result to
// decimal by repeated subtraction, then shows each item on one 7-segment display with blank gaps.
module quiz_display_seq #(
    parameter int unsigned HOLD_CYCLES = 150000000,
    parameter int unsigned GAP_CYCLES  = 5000000,
    parameter int unsigned CNT_W       = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] num_a,
    input  logic [3:0] num_b,
    input  logic [1:0] op,
    input  logic [6:0] result,
    output logic [6:0] num_led,
    output logic [2:0] op_led,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE, S_CONV, S_SHOW_A, S_GAP1, S_SHOW_B, S_GAP2,
        S_SHOW_T, S_GAP3, S_SHOW_U, S_DONE
    } state_t;

    localparam logic [6:0] DASH = 7'b0000001;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [6:0]       r_rem;
    logic [3:0]       r_tens;
    logic             r_err;
    logic [6:0]       r_num_led;
    logic [2:0]       r_op_led;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last_hold;
    logic             w_last_gap;
    logic             w_timed;
    logic [6:0]       w_num_led;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = DASH;
        endcase
    endfunction

    function automatic logic [2:0] op_decode(input logic [1:0] code);
        case (code)
            2'd0:    op_decode = 3'b001;
            2'd1:    op_decode = 3'b010;
            2'd2:    op_decode = 3'b100;
            default: op_decode = 3'b000;
        endcase
    endfunction

    assign w_last_hold = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign w_last_gap  = (r_cnt == CNT_W'(GAP_CYCLES - 1));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_timed  = 1'b1;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_timed = 1'b0;
                if (start) begin
                    w_next   = S_CONV;
                    w_accept = 1'b1;
                end
            end
            S_CONV: begin
                w_timed = 1'b0;
                if (r_rem > 7'd99 || r_rem < 7'd10) w_next = S_SHOW_A;
            end
            S_SHOW_A: if (w_last_hold) w_next = S_GAP1;
            S_GAP1:   if (w_last_gap)  w_next = S_SHOW_B;
            S_SHOW_B: if (w_last_hold) w_next = S_GAP2;
            // A zero tens digit is suppressed unless the result was out of range
            S_GAP2:   if (w_last_gap)  w_next = (r_tens == 4'd0 && !r_err) ? S_SHOW_U : S_SHOW_T;
            S_SHOW_T: if (w_last_hold) w_next = S_GAP3;
            S_GAP3:   if (w_last_gap)  w_next = S_SHOW_U;
            S_SHOW_U: if (w_last_hold) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Display follows the next state so each digit appears on the edge that enters its state
    always_comb begin
        w_num_led = '0;
        case (w_next)
            S_SHOW_A: w_num_led = seg7(r_a);
            S_SHOW_B: w_num_led = seg7(r_b);
            S_SHOW_T: w_num_led = r_err ? DASH : seg7(r_tens);
            S_SHOW_U: w_num_led = r_err ? DASH : seg7(r_rem[3:0]);
            S_DONE:   w_num_led = r_num_led;
            default:  w_num_led = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_tens    <= '0;
            r_err     <= 1'b0;
            r_num_led <= '0;
            r_op_led  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_num_led <= w_num_led;
            r_busy    <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done    <= (w_next == S_DONE) && (r_state != S_DONE);
            r_cnt     <= (w_next != r_state || !w_timed) ? '0 : r_cnt + 1'b1;
            if (w_accept) begin
                r_a      <= num_a;
                r_b      <= num_b;
                r_rem    <= result;
                r_tens   <= '0;
                r_err    <= 1'b0;
                r_op_led <= op_decode(op);
            end else if (r_state == S_CONV) begin
                if (r_rem > 7'd99) begin
                    r_err <= 1'b1;
                end else if (r_rem >= 7'd10) begin
                    r_rem  <= r_rem - 7'd10;
                    r_tens <= r_tens + 4'd1;
                end
            end
        end
    end

    assign num_led = r_num_led;
    assign op_led  = r_op_led;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_quiz_display_seq.sv
// Self-checking bench for quiz_display_seq: a per-cycle expected display trace is built
// from the question's arithmetic (tens/units, error) and compared against the DUT.
module tb_quiz_display_seq;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam logic [6:0] DASH = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_a;
    logic [3:0] num_b;
    logic [1:0] op;
    logic [6:0] result;
    logic [6:0] num_led;
    logic [2:0] op_led;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [6:0] exp_q [$];

    quiz_display_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .num_a(num_a), .num_b(num_b),
        .op(op), .result(result), .num_led(num_led), .op_led(op_led),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(int d);
        if (d > 9) return DASH;
        return seg_tab[d];
    endfunction

    function automatic logic [2:0] ref_op(int o);
        if (o == 0) return 3'b001;
        if (o == 1) return 3'b010;
        if (o == 2) return 3'b100;
        return 3'b000;
    endfunction

    // Expected num_led for every busy cycle, starting with the first conversion cycle
    task automatic build_model(int a, int b, int res);
        bit err = (res > 99);
        int t = res / 10;
        int u = res % 10;
        int clen = err ? 1 : t + 1;
        exp_q.delete();
        repeat (clen) exp_q.push_back(7'b0);
        repeat (HOLD) exp_q.push_back(ref_seg(a));
        repeat (GAP)  exp_q.push_back(7'b0);
        repeat (HOLD) exp_q.push_back(ref_seg(b));
        repeat (GAP)  exp_q.push_back(7'b0);
        if (err || t != 0) begin
            repeat (HOLD) exp_q.push_back(err ? DASH : ref_seg(t));
            repeat (GAP)  exp_q.push_back(7'b0);
        end
        repeat (HOLD) exp_q.push_back(err ? DASH : ref_seg(u));
    endtask

    // Issues a start, then follows the whole sequence; inj >= 0 fires a second start with
    // different inputs while sampling busy cycle inj, which must have no effect.
    task automatic test_sequence(string name, int a, int b, int o, int res, int inj);
        int n;
        logic [6:0] last;
        build_model(a, b, res);
        n = exp_q.size();
        last = exp_q[n-1];
        num_a = a[3:0]; num_b = b[3:0]; op = o[1:0]; result = res[6:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (op_led !== ref_op(o)) begin
            errors++;
            $display("FAIL %s op_led got %b exp %b", name, op_led, ref_op(o));
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (num_led !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d num_led/busy/done got %b/%b/%b exp %b/1/0",
                         name, i, num_led, busy, done, exp_q[i]);
            end
            if (i == inj) begin
                start  = 1'b1;
                num_a  = 4'($urandom_range(0, 15));
                num_b  = 4'($urandom_range(0, 15));
                op     = 2'($urandom_range(0, 3));
                result = 7'($urandom_range(0, 127));
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || num_led !== last || op_led !== ref_op(o)) begin
            errors++;
            $display("FAIL %s done_cycle done/busy/num_led/op_led got %b/%b/%b/%b exp 1/0/%b/%b",
                     name, done, busy, num_led, op_led, last, ref_op(o));
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || num_led !== last) begin
            errors++;
            $display("FAIL %s after_done done/busy/num_led got %b/%b/%b exp 0/0/%b",
                     name, done, busy, num_led, last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        num_a = '0; num_b = '0; op = '0; result = '0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (num_led !== 7'b0 || op_led !== 3'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset num_led/op_led/busy/done got %b/%b/%b/%b exp 0/0/0/0",
                     num_led, op_led, busy, done);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (num_led !== 7'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle num_led/busy/done got %b/%b/%b exp 0/0/0", num_led, busy, done);
        end
    endtask

    task automatic test_add_two_digit();
        test_sequence("add_two_digit", 7, 3, 0, 10, -1);
    endtask

    task automatic test_mul_single_digit();
        test_sequence("mul_single_digit", 5, 1, 2, 5, -1);
    endtask

    task automatic test_max_result();
        test_sequence("max_result", 9, 9, 2, 81, -1);
    endtask

    task automatic test_start_while_busy();
        // result 10: two conversion cycles, so SHOW_B spans busy cycles 8..11
        test_sequence("start_in_show_b", 4, 6, 0, 10, 9);
        // accepted from DONE; a start in its final SHOW_U cycle must be ignored
        test_sequence("start_in_done", 6, 2, 1, 4, 16);
    endtask

    task automatic test_invalid_inputs();
        test_sequence("invalid_inputs", 12, 3, 3, 120, -1);
    endtask

    task automatic test_async_reset();
        num_a = 4'd3; num_b = 4'd4; op = 2'd0; result = 7'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // one conversion cycle, then SHOW_A(4) GAP1(2): cycle 8 lies inside SHOW_B
        repeat (8) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || num_led !== seg_tab[4]) begin
            errors++;
            $display("FAIL async_pre busy/num_led got %b/%b exp 1/%b", busy, num_led, seg_tab[4]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (num_led !== 7'b0 || op_led !== 3'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset num_led/op_led/busy/done got %b/%b/%b/%b exp 0/0/0/0",
                     num_led, op_led, busy, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        test_sequence("after_reset", 8, 2, 1, 6, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int a   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            int b   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            int o   = $urandom_range(0, 3);
            int res = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 99);
            test_sequence("random", a, b, o, res, -1);
        end
    endtask

    initial begin
        test_reset();
        test_add_two_digit();
        test_mul_single_digit();
        test_max_result();
        test_start_while_busy();
        test_invalid_inputs();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
